hazard_fwd_unit: RTL and testbench

- Parametrised hazard-detection and operand-forwarding unit for the next-generation pipelined core.
- Sits between decode and execute. Tracks every in-flight register writer in an internal token pipeline.
- Selects forwarded operand data for NUM_SRC decode operands, raises load-use stalls, inserts bubbles on stall/flush, and counts stall/flush events.
- Replaces the fixed two-way EX-result muxes with a general N-stage, N-operand scheme.

---
 rtl/hazard_fwd_unit_pkg.sv | 27 ++
 rtl/hazard_fwd_unit_if.sv | 40 ++++
 rtl/hazard_fwd_unit_fwd_operand_sel.sv | 65 ++++++
 rtl/hazard_fwd_unit.sv | 98 +++++++++
 tb/tb_hazard_fwd_unit.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and helpers for the hazard-detection / operand-forwarding unit.
// Tokens carry a fixed-width destination field so the type does not depend on module parameters.
package hazard_fwd_unit_pkg;

  localparam int TOK_AW      = 8;
  localparam int NUM_STG_DEF = 3;
  localparam int SEL_W       = $clog2(NUM_STG_DEF + 1);

  typedef struct packed {
    logic              valid;
    logic [TOK_AW-1:0] dst;
    logic              wen;
    logic              is_load;
  } token_t;

  function automatic int calc_sel_w(input int num_stg);
    return $clog2(num_stg + 1);
  endfunction

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] lim;
    lim = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side and stage-result bundle between the core pipeline and hazard_fwd_unit.
// The master drives decode and stage data; the slave (the unit) returns forwarding and stall results.
interface hazard_fwd_unit_if #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 3,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = hazard_fwd_unit_pkg::calc_sel_w(NUM_STG);

  logic                        dec_valid;
  logic [NUM_SRC*REG_AW-1:0]   dec_src_addr;
  logic [NUM_SRC-1:0]          dec_src_used;
  logic [NUM_SRC*DATA_W-1:0]   dec_src_rf;
  logic [REG_AW-1:0]           dec_dst_addr;
  logic                        dec_wen;
  logic                        dec_is_load;
  logic                        flush;
  logic [NUM_STG*DATA_W-1:0]   stg_data;

  logic [NUM_SRC*DATA_W-1:0]   src_fwd_data;
  logic [NUM_SRC*SEL_W-1:0]    src_fwd_sel;
  logic                        stall;
  logic [NUM_STG-1:0]          stg_valid;
  logic [CNT_W-1:0]            stall_cnt;
  logic [CNT_W-1:0]            flush_cnt;

  modport master (
    output dec_valid, dec_src_addr, dec_src_used, dec_src_rf, dec_dst_addr,
           dec_wen, dec_is_load, flush, stg_data,
    input  src_fwd_data, src_fwd_sel, stall, stg_valid, stall_cnt, flush_cnt
  );

  modport slave (
    input  dec_valid, dec_src_addr, dec_src_used, dec_src_rf, dec_dst_addr,
           dec_wen, dec_is_load, flush, stg_data,
    output src_fwd_data, src_fwd_sel, stall, stg_valid, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit_fwd_operand_sel.sv
// Per-operand forwarding selector: finds the youngest in-flight writer of the source register
// and either forwards its stage result or flags a not-yet-ready load as a hazard.
module fwd_operand_sel
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int NUM_STG      = 3,
  parameter int LOAD_RDY_STG = 2,
  parameter int ZERO_REG_EN  = 0,
  parameter int SEL_W        = 2
) (
  input  logic [REG_AW-1:0]         i_src_addr,
  input  logic                      i_src_used,
  input  logic [DATA_W-1:0]         i_src_rf,
  input  token_t                    i_tok [NUM_STG],
  input  logic [NUM_STG*DATA_W-1:0] i_stg_data,
  output logic [DATA_W-1:0]         o_data,
  output logic [SEL_W-1:0]          o_sel,
  output logic                      o_hazard
);

  logic              w_zero_src;
  logic              w_hit;
  logic              w_hit_load;
  logic [SEL_W-1:0]  w_hit_stg;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_ready;

  assign w_zero_src = (ZERO_REG_EN != 0) && (i_src_addr == '0);

  // Scan oldest to youngest so the youngest matching stage is the last one written.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_load = 1'b0;
    w_hit_stg  = '0;
    w_hit_data = '0;
    for (int s = NUM_STG - 1; s >= 0; s--) begin
      if (i_tok[s].valid && i_tok[s].wen && i_src_used && !w_zero_src &&
          (i_tok[s].dst == TOK_AW'(i_src_addr))) begin
        w_hit      = 1'b1;
        w_hit_load = i_tok[s].is_load;
        w_hit_stg  = SEL_W'(s + 1);
        w_hit_data = i_stg_data[s*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ready = !w_hit_load || (int'(w_hit_stg) >= LOAD_RDY_STG);

  always_comb begin
    o_data   = i_src_rf;
    o_sel    = '0;
    o_hazard = 1'b0;
    if (w_hit) begin
      if (w_ready) begin
        o_data = w_hit_data;
        o_sel  = w_hit_stg;
      end else begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard-detection and operand-forwarding unit between decode and execute.
// Tracks in-flight writers as a token shift pipe, resolves operands, stalls on load-use, counts events.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_AW       = 4,
  parameter int NUM_SRC      = 2,
  parameter int NUM_STG      = 3,
  parameter int LOAD_RDY_STG = 2,
  parameter int ZERO_REG_EN  = 0,
  parameter int CNT_W        = 16
) (
  input  logic               Clk,
  input  logic               Rst,
  hazard_fwd_unit_if.slave   bus
);

  localparam int STG_SEL_W = calc_sel_w(NUM_STG);

  token_t             r_tok [NUM_STG];
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  logic [NUM_SRC-1:0] w_hazard;
  logic               w_stall;
  logic               w_issue;
  logic               w_flush_evt;
  token_t             w_dec_tok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      fwd_operand_sel #(
        .DATA_W       (DATA_W),
        .REG_AW       (REG_AW),
        .NUM_STG      (NUM_STG),
        .LOAD_RDY_STG (LOAD_RDY_STG),
        .ZERO_REG_EN  (ZERO_REG_EN),
        .SEL_W        (STG_SEL_W)
      ) u_sel (
        .i_src_addr (bus.dec_src_addr[gi*REG_AW +: REG_AW]),
        .i_src_used (bus.dec_src_used[gi]),
        .i_src_rf   (bus.dec_src_rf[gi*DATA_W +: DATA_W]),
        .i_tok      (r_tok),
        .i_stg_data (bus.stg_data),
        .o_data     (bus.src_fwd_data[gi*DATA_W +: DATA_W]),
        .o_sel      (bus.src_fwd_sel[gi*STG_SEL_W +: STG_SEL_W]),
        .o_hazard   (w_hazard[gi])
      );
    end
  endgenerate

  // A killed decode instruction never stalls; flush takes priority over the hazard.
  assign w_stall     = bus.dec_valid && !bus.flush && (|w_hazard);
  assign w_issue     = bus.dec_valid && !w_stall && !bus.flush;
  assign w_flush_evt = bus.dec_valid && bus.flush;
  assign bus.stall   = w_stall;

  always_comb begin
    w_dec_tok         = '0;
    w_dec_tok.valid   = w_issue;
    w_dec_tok.dst     = TOK_AW'(bus.dec_dst_addr);
    w_dec_tok.wen     = bus.dec_wen;
    w_dec_tok.is_load = bus.dec_is_load;
  end

  // Stage 1 takes the decode token or a bubble; downstream stages shift unconditionally.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int s = 0; s < NUM_STG; s++) r_tok[s] <= '0;
    end else begin
      r_tok[0] <= w_dec_tok;
      for (int s = 1; s < NUM_STG; s++) r_tok[s] <= r_tok[s-1];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall)
        r_stall_cnt <= CNT_W'(sat_inc(32'(r_stall_cnt), CNT_W));
      if (w_flush_evt)
        r_flush_cnt <= CNT_W'(sat_inc(32'(r_flush_cnt), CNT_W));
    end
  end

  always_comb begin
    bus.stg_valid = '0;
    for (int s = 0; s < NUM_STG; s++) bus.stg_valid[s] = r_tok[s].valid;
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: reset, forwarding priority, load-use stall, zero register,
// flush-over-stall and asynchronous reset, each with hand-computed expectations.
module tb_hazard_fwd_unit;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int NSRC   = 2;
  localparam int NSTG   = 3;
  localparam int CNT_W  = 16;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  hazard_fwd_unit_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NSRC),
                       .NUM_STG(NSTG), .CNT_W(CNT_W)) bus ();

  hazard_fwd_unit #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NSRC), .NUM_STG(NSTG),
    .LOAD_RDY_STG(2), .ZERO_REG_EN(1), .CNT_W(CNT_W)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Decode-slot driver; stage data and rf data are driven directly.
  task automatic set_dec(input logic v, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [1:0] used, input logic [3:0] dst,
                         input logic wen, input logic ld);
    bus.dec_valid    = v;
    bus.dec_src_addr = {a1, a0};
    bus.dec_src_used = used;
    bus.dec_dst_addr = dst;
    bus.dec_wen      = wen;
    bus.dec_is_load  = ld;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    set_dec(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    bus.flush = 1'b0;
    repeat (NSTG) tick();
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    set_dec(1'b0, 4'd1, 4'd2, 2'b11, 4'd0, 1'b0, 1'b0);
    bus.flush      = 1'b0;
    bus.dec_src_rf = {16'h1111, 16'h2222};
    bus.stg_data   = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    @(negedge Clk);
    tests_run++;
    if (bus.src_fwd_data !== 32'h1111_2222) begin
      tests_failed++; $display("FAIL reset_data: got %h expected %h", bus.src_fwd_data, 32'h1111_2222);
    end
    tests_run++;
    if (bus.src_fwd_sel !== 4'h0) begin
      tests_failed++; $display("FAIL reset_sel: got %h expected 0", bus.src_fwd_sel);
    end
    tests_run++;
    if (bus.stall !== 1'b0 || bus.stg_valid !== 3'b000) begin
      tests_failed++; $display("FAIL reset_ctrl: stall %b stg_valid %b expected 0/000", bus.stall, bus.stg_valid);
    end
    tests_run++;
    if (bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_cnt: stall_cnt %0d flush_cnt %0d expected 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    #2 Rst = 1'b1;
    drain();
  endtask

  task automatic test_alu_forward();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 4'd3, 4'd9, 2'b01, 4'd8, 1'b1, 1'b0);
    bus.dec_src_rf = {16'h5555, 16'h1234};
    bus.stg_data   = {16'h0000, 16'h0000, 16'h00A5};
    @(negedge Clk);
    tests_run++;
    if (bus.src_fwd_sel[1:0] !== 2'd1 || bus.src_fwd_data[15:0] !== 16'h00A5) begin
      tests_failed++; $display("FAIL alu_fwd: sel %0d data %h expected 1/00a5", bus.src_fwd_sel[1:0], bus.src_fwd_data[15:0]);
    end
    tests_run++;
    if (bus.stall !== 1'b0 || bus.stg_valid !== 3'b001) begin
      tests_failed++; $display("FAIL alu_fwd_ctrl: stall %b stg_valid %b expected 0/001", bus.stall, bus.stg_valid);
    end
    drain();
  endtask

  task automatic test_load_use();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 4'd4, 4'd0, 2'b01, 4'd10, 1'b1, 1'b0);
    bus.dec_src_rf = {16'h0000, 16'h7777};
    bus.stg_data   = {16'h0000, 16'hBEEF, 16'hDEAD};
    @(negedge Clk);
    tests_run++;
    if (bus.stall !== 1'b1 || bus.src_fwd_sel[1:0] !== 2'd0) begin
      tests_failed++; $display("FAIL load_use_stall: stall %b sel %0d expected 1/0", bus.stall, bus.src_fwd_sel[1:0]);
    end
    tick();
    @(negedge Clk);
    tests_run++;
    if (bus.stall !== 1'b0 || bus.stall_cnt !== 16'd1 || bus.stg_valid !== 3'b010) begin
      tests_failed++; $display("FAIL load_use_release: stall %b cnt %0d stg_valid %b expected 0/1/010",
                               bus.stall, bus.stall_cnt, bus.stg_valid);
    end
    tests_run++;
    if (bus.src_fwd_sel[1:0] !== 2'd2 || bus.src_fwd_data[15:0] !== 16'hBEEF) begin
      tests_failed++; $display("FAIL load_fwd: sel %0d data %h expected 2/beef", bus.src_fwd_sel[1:0], bus.src_fwd_data[15:0]);
    end
    tick();
    set_dec(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.stall_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL stall_cnt_hold: got %0d expected 1", bus.stall_cnt);
    end
    drain();
  endtask

  task automatic test_youngest_wins();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0);
    tick();
    set_dec(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    tick();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 4'd5, 4'd5, 2'b10, 4'd11, 1'b1, 1'b0);
    bus.dec_src_rf = {16'h6666, 16'h4444};
    bus.stg_data   = {16'h0003, 16'h0002, 16'h0001};
    @(negedge Clk);
    tests_run++;
    if (bus.src_fwd_sel[3:2] !== 2'd1 || bus.src_fwd_data[31:16] !== 16'h0001) begin
      tests_failed++; $display("FAIL youngest: sel %0d data %h expected 1/0001", bus.src_fwd_sel[3:2], bus.src_fwd_data[31:16]);
    end
    tests_run++;
    if (bus.src_fwd_sel[1:0] !== 2'd0 || bus.src_fwd_data[15:0] !== 16'h4444) begin
      tests_failed++; $display("FAIL unused_op: sel %0d data %h expected 0/4444", bus.src_fwd_sel[1:0], bus.src_fwd_data[15:0]);
    end
    set_dec(1'b0, 4'd5, 4'd5, 2'b10, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    set_dec(1'b1, 4'd5, 4'd5, 2'b10, 4'd11, 1'b1, 1'b0);
    @(negedge Clk);
    tests_run++;
    if (bus.src_fwd_sel[3:2] !== 2'd3 || bus.src_fwd_data[31:16] !== 16'h0003) begin
      tests_failed++; $display("FAIL wb_fwd: sel %0d data %h expected 3/0003", bus.src_fwd_sel[3:2], bus.src_fwd_data[31:16]);
    end
    drain();
  endtask

  task automatic test_zero_reg();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 4'd0, 4'd0, 2'b01, 4'd12, 1'b1, 1'b0);
    bus.dec_src_rf = {16'h0000, 16'h0000};
    bus.stg_data   = {16'h0000, 16'h0000, 16'hFACE};
    @(negedge Clk);
    tests_run++;
    if (bus.src_fwd_sel[1:0] !== 2'd0 || bus.src_fwd_data[15:0] !== 16'h0000 || bus.stall !== 1'b0) begin
      tests_failed++; $display("FAIL zero_reg: sel %0d data %h stall %b expected 0/0000/0",
                               bus.src_fwd_sel[1:0], bus.src_fwd_data[15:0], bus.stall);
    end
    drain();
  endtask

  task automatic test_flush_over_stall();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd6, 1'b1, 1'b1);
    tick();
    set_dec(1'b1, 4'd6, 4'd0, 2'b01, 4'd13, 1'b1, 1'b0);
    bus.flush = 1'b1;
    @(negedge Clk);
    tests_run++;
    if (bus.stall !== 1'b0) begin
      tests_failed++; $display("FAIL flush_stall: got stall %b expected 0", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    set_dec(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    @(negedge Clk);
    tests_run++;
    if (bus.stg_valid[0] !== 1'b0 || bus.flush_cnt !== 16'd1 || bus.stall_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL flush_after: stg_valid[0] %b flush_cnt %0d stall_cnt %0d expected 0/1/1",
                               bus.stg_valid[0], bus.flush_cnt, bus.stall_cnt);
    end
    drain();
  endtask

  task automatic test_async_reset();
    set_dec(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b0);
    tick();
    set_dec(1'b1, 4'd7, 4'd0, 2'b01, 4'd14, 1'b1, 1'b0);
    bus.dec_src_rf = {16'h0000, 16'h9999};
    @(negedge Clk);
    tests_run++;
    if (bus.stg_valid !== 3'b001 || bus.src_fwd_sel[1:0] !== 2'd1) begin
      tests_failed++; $display("FAIL pre_reset: stg_valid %b sel %0d expected 001/1", bus.stg_valid, bus.src_fwd_sel[1:0]);
    end
    #1 Rst = 1'b0;
    #1;
    tests_run++;
    if (bus.stg_valid !== 3'b000 || bus.stall_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL async_reset: stg_valid %b stall_cnt %0d flush_cnt %0d expected 000/0/0",
                               bus.stg_valid, bus.stall_cnt, bus.flush_cnt);
    end
    tests_run++;
    if (bus.src_fwd_sel[1:0] !== 2'd0 || bus.src_fwd_data[15:0] !== 16'h9999) begin
      tests_failed++; $display("FAIL reset_fwd: sel %0d data %h expected 0/9999", bus.src_fwd_sel[1:0], bus.src_fwd_data[15:0]);
    end
    #1 Rst = 1'b1;
    set_dec(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0);
    tick();
    tests_run++;
    if (bus.stg_valid !== 3'b000) begin
      tests_failed++; $display("FAIL post_reset: stg_valid %b expected 000", bus.stg_valid);
    end
  endtask

  initial begin
    test_reset();
    test_alu_forward();
    test_load_use();
    test_youngest_wins();
    test_zero_reg();
    test_flush_over_stall();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
